// File: rtl/noc_params.sv
// Shared NoC types: port encoding, flit types and the flit structure
// carried between the router input stage, allocator and crossbar.
package noc_params;

    localparam int PORT_NUM  = 5;
    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int DATA_W    = 16;
    localparam int VC_W      = 2;

    typedef logic [PORT_SIZE-1:0] port_t;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } ftype_t;

    typedef struct packed {
        ftype_t              ftype;
        logic [VC_W-1:0]     vc;
        port_t               out_port;
        logic [DATA_W-1:0]   data;
    } flit_t;

    function automatic logic is_head(input ftype_t t);
        return (t == HEAD) || (t == HEADTAIL);
    endfunction

    function automatic logic is_tail(input ftype_t t);
        return (t == TAIL) || (t == HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is silently discarded.
module vc_fifo
    import noc_params::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic  clk,
    input  logic  RST,
    input  logic  i_push,
    input  flit_t i_flit,
    input  logic  i_pop,
    output flit_t o_head,
    output logic  o_empty,
    output logic  o_full
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    flit_t             r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(BUF_DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers wrap naturally because BUF_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_flit;
    end

endmodule

// File: rtl/input_vc_unit.sv
// Router input port: per-VC buffering, route latching per packet, switch
// requests toward the allocator and a registered flit/credit output stage.
module input_vc_unit
    import noc_params::*;
#(
    parameter  int VC_NUM    = 2,
    parameter  int BUF_DEPTH = 4,
    localparam int VC_PTR_W  = (VC_NUM <= 1) ? 1 : $clog2(VC_NUM)
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       flit_in_valid,
    input  flit_t                      flit_in,
    output logic                       credit_out_valid,
    output logic [VC_PTR_W-1:0]        credit_out_vc,
    output logic [VC_NUM-1:0]          vc_request,
    output port_t [VC_NUM-1:0]         vc_target_port,
    input  logic [VC_NUM-1:0]          vc_grant,
    output logic                       flit_out_valid,
    output flit_t                      flit_out,
    output logic                       proto_err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [VC_NUM-1:0]   r_state;
    port_t [VC_NUM-1:0]  r_target;

    logic [VC_NUM-1:0]   w_empty;
    logic [VC_NUM-1:0]   w_full;
    logic [VC_NUM-1:0]   w_push;
    logic [VC_NUM-1:0]   w_pop;
    logic [VC_NUM-1:0]   w_req;
    logic [VC_NUM-1:0]   w_route;
    logic [VC_NUM-1:0]   w_drop_cand;
    flit_t               w_head [VC_NUM];

    logic                w_gnt_any;
    logic [VC_PTR_W-1:0] w_gnt_sel;
    logic                w_drop_any;
    logic [VC_PTR_W-1:0] w_drop_sel;
    logic                w_drop_go;
    logic                w_multi;
    logic                w_vc_ok;
    logic                w_ovf;
    logic                w_wr_err;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        assign w_push[v]      = flit_in_valid && !RST && (flit_in.vc == VC_W'(v));
        assign w_req[v]       = (r_state[v] == S_ACTIVE) && !w_empty[v];
        assign w_route[v]     = (r_state[v] == S_IDLE) && !w_empty[v] && is_head(w_head[v].ftype);
        assign w_drop_cand[v] = (r_state[v] == S_IDLE) && !w_empty[v] && !is_head(w_head[v].ftype);

        vc_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
            .clk     (clk),
            .RST     (RST),
            .i_push  (w_push[v]),
            .i_flit  (flit_in),
            .i_pop   (w_pop[v]),
            .o_head  (w_head[v]),
            .o_empty (w_empty[v]),
            .o_full  (w_full[v])
        );
    end

    assign vc_request     = w_req;
    assign vc_target_port = r_target;

    // Descending scans leave the lowest-index candidate selected.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_sel  = '0;
        w_drop_any = 1'b0;
        w_drop_sel = '0;
        for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (vc_grant[v] && w_req[v]) begin
                w_gnt_any = 1'b1;
                w_gnt_sel = VC_PTR_W'(v);
            end
            if (w_drop_cand[v]) begin
                w_drop_any = 1'b1;
                w_drop_sel = VC_PTR_W'(v);
            end
        end
    end

    // One credit per cycle: a switch pop wins, stray body flits wait.
    always_comb begin
        w_drop_go = w_drop_any && !w_gnt_any;
        w_pop     = '0;
        if (w_gnt_any)      w_pop[w_gnt_sel]  = 1'b1;
        else if (w_drop_go) w_pop[w_drop_sel] = 1'b1;
    end

    always_comb begin
        w_vc_ok = 1'b0;
        w_ovf   = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (flit_in.vc == VC_W'(v)) begin
                w_vc_ok = 1'b1;
                if (w_full[v] && !w_pop[v]) w_ovf = 1'b1;
            end
        end
        w_wr_err = flit_in_valid && (w_ovf || !w_vc_ok);
        w_multi  = ($countones(vc_grant) > 1);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state          <= '0;
            r_target         <= '0;
            flit_out_valid   <= 1'b0;
            flit_out         <= '0;
            credit_out_valid <= 1'b0;
            credit_out_vc    <= '0;
            proto_err        <= 1'b0;
        end else begin
            flit_out_valid   <= w_gnt_any;
            credit_out_valid <= w_gnt_any || w_drop_go;
            proto_err        <= proto_err || w_multi || w_wr_err || w_drop_go;
            if (w_gnt_any) begin
                flit_out      <= w_head[w_gnt_sel];
                credit_out_vc <= w_gnt_sel;
            end else if (w_drop_go) begin
                credit_out_vc <= w_drop_sel;
            end
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_route[v]) begin
                    r_state[v]  <= S_ACTIVE;
                    r_target[v] <= w_head[v].out_port;
                end else if (w_gnt_any && (w_gnt_sel == VC_PTR_W'(v)) && is_tail(w_head[v].ftype)) begin
                    r_state[v]  <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_vc_unit.sv
// Directed scenarios for input_vc_unit with a queue-based scoreboard that
// checks every flit/credit pulse the DUT emits.
module tb_input_vc_unit;
    import noc_params::*;

    logic            clk = 1'b0;
    logic            RST;
    logic            flit_in_valid;
    flit_t           flit_in;
    logic            credit_out_valid;
    logic [0:0]      credit_out_vc;
    logic [1:0]      vc_request;
    port_t [1:0]     vc_target_port;
    logic [1:0]      vc_grant;
    logic            flit_out_valid;
    flit_t           flit_out;
    logic            proto_err;

    input_vc_unit #(.VC_NUM(2), .BUF_DEPTH(4)) dut (
        .clk              (clk),
        .RST              (RST),
        .flit_in_valid    (flit_in_valid),
        .flit_in          (flit_in),
        .credit_out_valid (credit_out_valid),
        .credit_out_vc    (credit_out_vc),
        .vc_request       (vc_request),
        .vc_target_port   (vc_target_port),
        .vc_grant         (vc_grant),
        .flit_out_valid   (flit_out_valid),
        .flit_out         (flit_out),
        .proto_err        (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  fv;
        int    vc;
        flit_t flit;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic flit_t mk(input ftype_t t, input int vc, input int port, input int data);
        flit_t f;
        f.ftype    = t;
        f.vc       = VC_W'(vc);
        f.out_port = PORT_SIZE'(port);
        f.data     = DATA_W'(data);
        return f;
    endfunction

    task automatic expect_out(input logic fv, input int vc, input flit_t f);
        exp_t e;
        e.fv   = fv;
        e.vc   = vc;
        e.flit = f;
        q.push_back(e);
    endtask

    // Monitor: every output pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (flit_out_valid === 1'b1 || credit_out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {30'd0, flit_out_valid, credit_out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("credit_out_valid", 32'(credit_out_valid), 32'd1);
                chk("flit_out_valid", 32'(flit_out_valid), 32'(e.fv));
                chk("credit_out_vc", 32'(credit_out_vc), 32'(e.vc));
                if (e.fv) chk("flit_out", 32'(flit_out), 32'(e.flit));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input flit_t f);
        flit_in_valid = 1'b1;
        flit_in       = f;
        tick();
        flit_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_vc_request", 32'(vc_request), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_flit_out_valid", 32'(flit_out_valid), 32'd0);
        chk("rst_credit_valid", 32'(credit_out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        flit_t f0, f1, f2;
        RST           = 1'b1;
        flit_in_valid = 1'b0;
        flit_in       = '0;
        vc_grant      = '0;

        // Reset state, then a single HEADTAIL on vc0 to port 3
        do_reset();
        chk("rst_target", 32'(vc_target_port), 32'd0);
        chk("rst_flit_out", 32'(flit_out), 32'd0);
        f0 = mk(HEADTAIL, 0, 3, 16'h1111);
        send(f0);
        chk("ht_req_before_route", 32'(vc_request), 32'd0);
        tick();
        chk("ht_vc_request", 32'(vc_request), 32'd1);
        chk("ht_target0", 32'(vc_target_port[0]), 32'd3);
        expect_out(1'b1, 0, f0);
        vc_grant = 2'b01;
        tick();
        vc_grant = 2'b00;
        chk("ht_flit_out_valid", 32'(flit_out_valid), 32'd1);
        chk("ht_req_after_pop", 32'(vc_request), 32'd0);
        tick();
        chk("ht_pulse_drops", 32'(flit_out_valid), 32'd0);

        // HEAD, BODY, TAIL on vc1 to port 2, granted every cycle
        f0 = mk(HEAD, 1, 2, 16'hA000);
        f1 = mk(BODY, 1, 2, 16'hA001);
        f2 = mk(TAIL, 1, 2, 16'hA002);
        expect_out(1'b1, 1, f0);
        expect_out(1'b1, 1, f1);
        expect_out(1'b1, 1, f2);
        vc_grant = 2'b10;
        send(f0);
        send(f1);
        send(f2);
        chk("pkt_target1", 32'(vc_target_port[1]), 32'd2);
        chk("pkt_req_mid", 32'(vc_request), 32'd2);
        tick();
        tick();
        vc_grant = 2'b00;
        chk("pkt_req_after_tail", 32'(vc_request), 32'd0);
        chk("pkt_target1_hold", 32'(vc_target_port[1]), 32'd2);
        chk("pkt_no_err", 32'(proto_err), 32'd0);
        tick();

        // Fill vc0, push+pop on full, then overflow
        do_reset();
        send(mk(HEAD, 0, 1, 16'hB000));
        send(mk(BODY, 0, 1, 16'hB001));
        send(mk(BODY, 0, 1, 16'hB002));
        send(mk(BODY, 0, 1, 16'hB003));
        chk("full_no_err", 32'(proto_err), 32'd0);
        expect_out(1'b1, 0, mk(HEAD, 0, 1, 16'hB000));
        vc_grant = 2'b01;
        send(mk(TAIL, 0, 1, 16'hB004));
        vc_grant = 2'b00;
        chk("pushpop_no_err", 32'(proto_err), 32'd0);
        send(mk(BODY, 0, 1, 16'hB005));
        chk("overflow_err", 32'(proto_err), 32'd1);
        expect_out(1'b1, 0, mk(BODY, 0, 1, 16'hB001));
        expect_out(1'b1, 0, mk(BODY, 0, 1, 16'hB002));
        expect_out(1'b1, 0, mk(BODY, 0, 1, 16'hB003));
        expect_out(1'b1, 0, mk(TAIL, 0, 1, 16'hB004));
        vc_grant = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        vc_grant = 2'b00;
        chk("drain_req", 32'(vc_request), 32'd0);
        tick();

        // Stray BODY on idle vc1
        do_reset();
        expect_out(1'b0, 1, '0);
        send(mk(BODY, 1, 0, 16'hC000));
        tick();
        chk("stray_err", 32'(proto_err), 32'd1);
        chk("stray_credit", 32'(credit_out_valid), 32'd1);
        chk("stray_credit_vc", 32'(credit_out_vc), 32'd1);
        chk("stray_req", 32'(vc_request), 32'd0);
        tick();

        // Multi-hot grant and grants to non-requesting VCs
        do_reset();
        f0 = mk(HEADTAIL, 0, 1, 16'hD000);
        f1 = mk(HEADTAIL, 1, 4, 16'hD001);
        send(f0);
        send(f1);
        vc_grant = 2'b10;
        tick();
        vc_grant = 2'b00;
        chk("mh_both_req", 32'(vc_request), 32'd3);
        chk("mh_early_grant_ignored", 32'(flit_out_valid), 32'd0);
        expect_out(1'b1, 0, f0);
        vc_grant = 2'b11;
        tick();
        vc_grant = 2'b00;
        chk("mh_err", 32'(proto_err), 32'd1);
        chk("mh_only_vc0", 32'(vc_request), 32'd2);
        vc_grant = 2'b01;
        tick();
        vc_grant = 2'b00;
        chk("idle_grant_no_pop", 32'(flit_out_valid), 32'd0);
        expect_out(1'b1, 1, f1);
        vc_grant = 2'b10;
        tick();
        vc_grant = 2'b00;
        chk("mh_final_req", 32'(vc_request), 32'd0);
        tick();

        // Reset mid-packet, inputs ignored during reset, then reroute
        do_reset();
        send(mk(HEAD, 1, 2, 16'hE000));
        send(mk(BODY, 1, 2, 16'hE001));
        send(mk(BODY, 1, 2, 16'hE002));
        chk("mid_req", 32'(vc_request), 32'd2);
        RST           = 1'b1;
        flit_in_valid = 1'b1;
        flit_in       = mk(HEADTAIL, 0, 3, 16'hE0FF);
        vc_grant      = 2'b11;
        tick();
        RST           = 1'b0;
        flit_in_valid = 1'b0;
        vc_grant      = 2'b00;
        chk("mid_rst_req", 32'(vc_request), 32'd0);
        chk("mid_rst_credit", 32'(credit_out_valid), 32'd0);
        tick();
        tick();
        chk("rst_write_ignored", 32'(vc_request), 32'd0);
        f0 = mk(HEADTAIL, 1, 2, 16'hE100);
        send(f0);
        tick();
        chk("post_rst_req", 32'(vc_request), 32'd2);
        chk("post_rst_target", 32'(vc_target_port[1]), 32'd2);
        expect_out(1'b1, 1, f0);
        vc_grant = 2'b10;
        tick();
        vc_grant = 2'b00;
        chk("post_rst_done", 32'(vc_request), 32'd0);

        tick();
        tick();
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
